// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Holds the FSM state type, the error fetch word, latency limits and an index-width helper.
package imem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam logic [31:0] ImemErrInst = 32'h0000_0000;

  localparam int unsigned LatencyMin = 1;
  localparam int unsigned LatencyMax = 15;

  function automatic int unsigned idx_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response channel between the IFU (master) and the instruction memory (slave).
interface imem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic        rsp_err;

  modport master (
    output req_valid,
    output req_addr,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_inst,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_inst,
    output rsp_err
  );

endinterface

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port for program load, one asynchronous read port.
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  localparam int unsigned IdxW = idx_width(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [IdxW-1:0] widx,
  input  logic [31:0]     wdata,
  input  logic [IdxW-1:0] ridx,
  output logic [31:0]     rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Async read sees the pre-edge contents, so a same-edge write is not forwarded.
  assign rdata = mem[ridx];

endmodule

// File: rtl/imem_responder.sv
// Memory-side end of the instruction fetch channel: fixed-latency response with
// misalignment/range error flagging, plus an independent word-indexed load port.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 1,
  localparam int unsigned IdxW = idx_width(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  imem_responder_if.slave   bus,
  input  logic              ld_en,
  input  logic [IdxW-1:0]   ld_idx,
  input  logic [31:0]       ld_data
);

  if (LATENCY < LatencyMin || LATENCY > LatencyMax) begin : gen_bad_latency
    $error("imem_responder: LATENCY out of range 1..15");
  end
  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : gen_bad_depth
    $error("imem_responder: DEPTH_WORDS must be a power of two >= 2");
  end

  localparam logic [32:0] SizeBytes = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CntInit   = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_inst_q;
  logic        rsp_err_q;

  logic        req_ready;
  logic        req_fire;
  logic [31:0] cap_addr;
  logic [32:0] diff;
  logic        in_range;
  logic        cap_err;
  logic [31:0] cap_inst;
  logic [31:0] rdata;

  always_comb begin
    req_ready = 1'b0;
    if (rst) begin
      req_ready = (state_q == StIdle) | ((state_q == StResp) & bus.rsp_ready);
    end
  end

  assign req_fire = bus.req_valid & req_ready;

  // The capture edge uses the live request address when LATENCY==1, else the latched one.
  assign cap_addr = (state_q == StWait) ? addr_q : bus.req_addr;
  assign diff     = {1'b0, cap_addr} - {1'b0, BASE_ADDR};
  assign in_range = ~diff[32] & ({1'b0, diff[31:0]} < SizeBytes);
  assign cap_err  = (|cap_addr[1:0]) | ~in_range;
  assign cap_inst = cap_err ? ImemErrInst : rdata;

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (ld_en),
    .widx (ld_idx),
    .wdata(ld_data),
    .ridx (diff[IdxW+1:2]),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_inst_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StResp: begin
          if (req_fire) begin
            addr_q <= bus.req_addr;
            if (LATENCY == 1) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_inst_q  <= cap_inst;
              rsp_err_q   <= cap_err;
            end else begin
              state_q     <= StWait;
              cnt_q       <= CntInit;
              rsp_valid_q <= 1'b0;
            end
          end else if (state_q == StResp && bus.rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rsp_inst_q  <= cap_inst;
            rsp_err_q   <= cap_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q     <= StIdle;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_inst  = rsp_inst_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: three instances at LATENCY 1, 3 and 4 sharing clock,
// reset and load port, each driven through its own fetch interface.
module tb_imem_responder;

  localparam int unsigned Depth = 4096;
  localparam int unsigned IdxW  = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic            ld_en;
  logic [IdxW-1:0] ld_idx;
  logic [31:0]     ld_data;

  int vectors    = 0;
  int miscompares = 0;

  imem_responder_if if1 ();
  imem_responder_if if3 ();
  imem_responder_if if4 ();

  imem_responder #(.DEPTH_WORDS(Depth), .BASE_ADDR(32'h0), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .bus(if1), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );
  imem_responder #(.DEPTH_WORDS(Depth), .BASE_ADDR(32'h0), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .bus(if3), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );
  imem_responder #(.DEPTH_WORDS(Depth), .BASE_ADDR(32'h0), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .bus(if4), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] prog [4];

  initial begin
    prog[0] = 32'h0000_0413;
    prog[1] = 32'h0010_0513;
    prog[2] = 32'h00a5_0533;
    prog[3] = 32'h0010_0073;

    rst = 1'b0; ld_en = 1'b0; ld_idx = '0; ld_data = '0;
    if1.req_valid = 1'b0; if1.req_addr = '0; if1.rsp_ready = 1'b0;
    if3.req_valid = 1'b0; if3.req_addr = '0; if3.rsp_ready = 1'b0;
    if4.req_valid = 1'b0; if4.req_addr = '0; if4.rsp_ready = 1'b0;
    tick();
    tick();

    // Reset state; req_ready held low during reset.
    chk("rst_rsp_valid", 32'(if1.rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(if1.rsp_err), 32'd0);
    chk("rst_rsp_inst", if1.rsp_inst, 32'h0);
    chk("rst_req_ready", 32'(if1.req_ready), 32'd0);
    chk("rst_req_ready_l3", 32'(if3.req_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("idle_req_ready", 32'(if1.req_ready), 32'd1);

    // Program load, including the last word of the array.
    ld_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_idx = IdxW'(i);
      ld_data = prog[i];
      tick();
    end
    ld_idx = IdxW'(Depth - 1);
    ld_data = 32'hdead_beef;
    tick();
    ld_en = 1'b0;

    // Back-to-back fetches at LATENCY 1.
    if1.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if1.req_valid = 1'b1;
      if1.req_addr = 32'(4 * i);
      tick();
      chk($sformatf("b2b_valid%0d", i), 32'(if1.rsp_valid), 32'd1);
      chk($sformatf("b2b_inst%0d", i), if1.rsp_inst, prog[i]);
      chk($sformatf("b2b_err%0d", i), 32'(if1.rsp_err), 32'd0);
    end
    if1.req_valid = 1'b0;
    tick();
    chk("b2b_drain", 32'(if1.rsp_valid), 32'd0);

    // LATENCY 3: response appears after the second edge following accept.
    if3.rsp_ready = 1'b1;
    if3.req_valid = 1'b1;
    if3.req_addr = 32'h4;
    tick();
    if3.req_valid = 1'b0;
    #1;
    chk("l3_wait1_valid", 32'(if3.rsp_valid), 32'd0);
    chk("l3_wait1_ready", 32'(if3.req_ready), 32'd0);
    tick();
    chk("l3_wait2_valid", 32'(if3.rsp_valid), 32'd0);
    chk("l3_wait2_ready", 32'(if3.req_ready), 32'd0);
    tick();
    chk("l3_valid", 32'(if3.rsp_valid), 32'd1);
    chk("l3_inst", if3.rsp_inst, 32'h0010_0513);
    tick();
    chk("l3_done", 32'(if3.rsp_valid), 32'd0);

    // Error cases, plus the last in-range word as a boundary.
    if1.req_valid = 1'b1;
    if1.req_addr = 32'h6;
    tick();
    chk("mis_err", 32'(if1.rsp_err), 32'd1);
    chk("mis_inst", if1.rsp_inst, 32'h0);
    if1.req_addr = 32'h4000;
    tick();
    chk("oor_err", 32'(if1.rsp_err), 32'd1);
    chk("oor_inst", if1.rsp_inst, 32'h0);
    if1.req_addr = 32'hffff_fffc;
    tick();
    chk("top_err", 32'(if1.rsp_err), 32'd1);
    if1.req_addr = 32'h3ffc;
    tick();
    chk("last_err", 32'(if1.rsp_err), 32'd0);
    chk("last_inst", if1.rsp_inst, 32'hdead_beef);
    if1.req_valid = 1'b0;
    tick();

    // Backpressure: response held, new request ignored.
    if1.rsp_ready = 1'b0;
    if1.req_valid = 1'b1;
    if1.req_addr = 32'h8;
    tick();
    if1.req_addr = 32'hc;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_ready%0d", i), 32'(if1.req_ready), 32'd0);
      tick();
      chk($sformatf("bp_valid%0d", i), 32'(if1.rsp_valid), 32'd1);
      chk($sformatf("bp_inst%0d", i), if1.rsp_inst, prog[2]);
      chk($sformatf("bp_err%0d", i), 32'(if1.rsp_err), 32'd0);
    end
    if1.req_valid = 1'b0;
    if1.rsp_ready = 1'b1;
    tick();
    chk("bp_release", 32'(if1.rsp_valid), 32'd0);
    tick();
    chk("bp_no_extra", 32'(if1.rsp_valid), 32'd0);

    // Reset in the middle of a LATENCY 4 wait drops the request.
    if4.rsp_ready = 1'b1;
    if4.req_valid = 1'b1;
    if4.req_addr = 32'hc;
    tick();
    if4.req_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(if4.req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("midrst_quiet%0d", i), 32'(if4.rsp_valid), 32'd0);
    end
    chk("midrst_inst", if4.rsp_inst, 32'h0);
    if4.req_valid = 1'b1;
    tick();
    if4.req_valid = 1'b0;
    tick();
    tick();
    chk("l4_early", 32'(if4.rsp_valid), 32'd0);
    tick();
    chk("l4_valid", 32'(if4.rsp_valid), 32'd1);
    chk("l4_inst", if4.rsp_inst, prog[3]);
    tick();

    // Write to the captured word on the capture edge returns the old word.
    if1.rsp_ready = 1'b1;
    if1.req_valid = 1'b1;
    if1.req_addr = 32'h8;
    ld_en = 1'b1;
    ld_idx = IdxW'(2);
    ld_data = 32'hcafe_f00d;
    tick();
    ld_en = 1'b0;
    chk("rbw_old", if1.rsp_inst, prog[2]);
    tick();
    chk("rbw_new", if1.rsp_inst, 32'hcafe_f00d);
    if1.req_valid = 1'b0;
    tick();
    chk("rbw_drain", 32'(if1.rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
